// File: rtl/block_packer.sv
// Byte-to-block packer with per-frame 0x80/zeros padding and valid/ready on both sides.
// Define BLOCK_PACKER_RTLEN_EN to add the runtime frame_len_i port (clamped to FRAME_BYTES).
module block_packer #(
  parameter int          BLOCK_BYTES = 8,
  parameter int          FRAME_BYTES = 181,
  parameter logic [7:0]  PAD_BYTE    = 8'h80
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     clear_i,
  input  logic                     s_valid_i,
  input  logic [7:0]               s_data_i,
  output logic                     s_ready_o,
  output logic                     m_valid_o,
  output logic [8*BLOCK_BYTES-1:0] m_data_o,
  output logic                     m_last_o,
  input  logic                     m_ready_i
`ifdef BLOCK_PACKER_RTLEN_EN
  ,
  input  logic [15:0]              frame_len_i
`endif
);

  localparam int LW = $clog2(BLOCK_BYTES);
  localparam int FW = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam int BW = 8 * BLOCK_BYTES;

  typedef enum logic {FILL, PAD} state_t;
  state_t state, state_nxt;

  logic [BW-1:0] acc;
  logic [LW-1:0] lane_cnt;
  logic [FW-1:0] frame_cnt;
  logic [FW-1:0] frame_end;
  logic          lane_last, frame_last, complete, out_free, accept;
  logic [BW-1:0] blk_nxt;
  logic          last_nxt;

`ifdef BLOCK_PACKER_RTLEN_EN
  logic [FW-1:0] len_end_q;
  logic [FW-1:0] len_end_in;

  function automatic logic [15:0] sat_len(input logic [15:0] len);
    if (len == 16'd0 || len > 16'(FRAME_BYTES)) return 16'(FRAME_BYTES);
    return len;
  endfunction

  assign len_end_in = FW'(sat_len(frame_len_i) - 16'd1);
  // The first byte of a frame compares against the live port value, later bytes against the sample.
  assign frame_end  = (frame_cnt == '0) ? len_end_in : len_end_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i)                          len_end_q <= FW'(FRAME_BYTES - 1);
    else if (accept && frame_cnt == '0)   len_end_q <= len_end_in;
  end
`else
  assign frame_end = FW'(FRAME_BYTES - 1);
`endif

  assign lane_last  = (lane_cnt == LW'(BLOCK_BYTES - 1));
  assign frame_last = (frame_cnt == frame_end);
  assign complete   = lane_last || frame_last;
  assign out_free   = !m_valid_o || m_ready_i;
  assign s_ready_o  = (state == FILL) && !(complete && !out_free);
  assign accept     = s_valid_i && s_ready_o;
  assign last_nxt   = frame_last && !lane_last;

  // Completed block: stored lanes, the incoming byte, then PAD_BYTE and zeros at end of frame.
  always_comb begin
    blk_nxt = '0;
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      if (i < int'(lane_cnt))
        blk_nxt[BW-8-8*i +: 8] = acc[BW-8-8*i +: 8];
      else if (i == int'(lane_cnt))
        blk_nxt[BW-8-8*i +: 8] = s_data_i;
      else if (i == int'(lane_cnt) + 1 && frame_last)
        blk_nxt[BW-8-8*i +: 8] = PAD_BYTE;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL: if (accept && frame_last && lane_last) state_nxt = PAD;
      PAD:  if (out_free) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i)      state <= FILL;
    else if (clear_i) state <= FILL;
    else              state <= state_nxt;
  end

  // Input side: accumulator and counters
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      acc       <= '0;
      lane_cnt  <= '0;
      frame_cnt <= '0;
    end else if (clear_i) begin
      acc       <= '0;
      lane_cnt  <= '0;
      frame_cnt <= '0;
    end else if (accept) begin
      acc[BW-8-8*int'(lane_cnt) +: 8] <= s_data_i;
      if (frame_last) begin
        lane_cnt  <= '0;
        frame_cnt <= '0;
      end else begin
        lane_cnt  <= lane_last ? '0 : lane_cnt + LW'(1);
        frame_cnt <= frame_cnt + FW'(1);
      end
    end
  end

  // Output side: one-block holding register
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      m_valid_o <= 1'b0;
      m_data_o  <= '0;
      m_last_o  <= 1'b0;
    end else if (clear_i) begin
      m_valid_o <= 1'b0;
      m_data_o  <= '0;
      m_last_o  <= 1'b0;
    end else if (state == FILL && accept && complete) begin
      m_valid_o <= 1'b1;
      m_data_o  <= blk_nxt;
      m_last_o  <= last_nxt;
    end else if (state == PAD && out_free) begin
      m_valid_o <= 1'b1;
      m_data_o  <= {PAD_BYTE, {(BW-8){1'b0}}};
      m_last_o  <= 1'b1;
    end else if (m_ready_i) begin
      m_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_block_packer.sv
// Randomised and directed bench for block_packer: a default instance (181-byte frames)
// and a 16-byte-frame instance share stimulus; each has its own queue-based reference model.
module tb_block_packer;
  localparam int BB = 8;

  logic        clk = 1'b0;
  logic        rst, clr, s_valid, m_ready;
  logic [7:0]  s_data;
  logic [15:0] frame_len;
  logic        ready_a, mv_a, ml_a, ready_b, mv_b, ml_b;
  logic [63:0] md_a, md_b;

  int checks = 0;
  int failures = 0;
  int fb_a = 181;
  int fb_b = 16;

  always #5 clk = ~clk;

  block_packer u_a (
    .clock_i(clk), .reset_i(rst), .clear_i(clr),
    .s_valid_i(s_valid), .s_data_i(s_data), .s_ready_o(ready_a),
    .m_valid_o(mv_a), .m_data_o(md_a), .m_last_o(ml_a), .m_ready_i(m_ready)
`ifdef BLOCK_PACKER_RTLEN_EN
    , .frame_len_i(frame_len)
`endif
  );

  block_packer #(.BLOCK_BYTES(8), .FRAME_BYTES(16), .PAD_BYTE(8'h80)) u_b (
    .clock_i(clk), .reset_i(rst), .clear_i(clr),
    .s_valid_i(s_valid), .s_data_i(s_data), .s_ready_o(ready_b),
    .m_valid_o(mv_b), .m_data_o(md_b), .m_last_o(ml_b), .m_ready_i(m_ready)
`ifdef BLOCK_PACKER_RTLEN_EN
    , .frame_len_i(frame_len)
`endif
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: shift bytes in from the right; a block is 8 bytes or whatever ends the frame, padded.
  task automatic model_byte(input int fb, input logic [7:0] b, inout logic [63:0] cur,
                            inout int n, inout int pos, output int nb,
                            output logic [64:0] b0, output logic [64:0] b1);
    nb = 0; b0 = '0; b1 = '0;
    cur = {cur[55:0], b};
    n++;
    pos++;
    if (n == BB) begin
      b0 = {1'b0, cur}; nb = 1; cur = '0; n = 0;
    end
    if (pos == fb) begin
      if (nb == 1) begin
        b1 = {1'b1, 8'h80, 56'h0}; nb = 2;
      end else begin
        cur = {cur[55:0], 8'h80}; n++;
        while (n < BB) begin cur = {cur[55:0], 8'h00}; n++; end
        b0 = {1'b1, cur}; nb = 1; cur = '0; n = 0;
      end
      pos = 0;
    end
  endtask

  logic [64:0] exp_a[$], exp_b[$], rec_a[$], rec_b[$];
  logic [63:0] cur_a, cur_b;
  int          n_a, pos_a, n_b, pos_b;
  logic        stall_a, stall_b;
  logic [64:0] held_a, held_b;

  function automatic logic [64:0] rec_get(input bit sel, input int i);
    if (!sel) return (i < rec_a.size()) ? rec_a[i] : '0;
    return (i < rec_b.size()) ? rec_b[i] : '0;
  endfunction

  initial begin : mon_a
    int nb; logic [64:0] b0, b1;
    stall_a = 1'b0; cur_a = '0; n_a = 0; pos_a = 0;
    forever begin
      @(negedge clk);
      if (rst || clr) begin
        exp_a.delete(); cur_a = '0; n_a = 0; pos_a = 0; stall_a = 1'b0;
      end else begin
        if (stall_a) check("hold_a", {mv_a, ml_a, md_a}, {1'b1, held_a});
        if (mv_a && m_ready) begin
          rec_a.push_back({ml_a, md_a});
          if (exp_a.size() == 0) check("extra_blk_a", exp_a.size(), 1);
          else check("blk_a", {ml_a, md_a}, exp_a.pop_front());
        end
        stall_a = mv_a && !m_ready;
        held_a = {ml_a, md_a};
        if (s_valid && ready_a) begin
          model_byte(fb_a, s_data, cur_a, n_a, pos_a, nb, b0, b1);
          if (nb > 0) exp_a.push_back(b0);
          if (nb > 1) exp_a.push_back(b1);
        end
      end
    end
  end

  initial begin : mon_b
    int nb; logic [64:0] b0, b1;
    stall_b = 1'b0; cur_b = '0; n_b = 0; pos_b = 0;
    forever begin
      @(negedge clk);
      if (rst || clr) begin
        exp_b.delete(); cur_b = '0; n_b = 0; pos_b = 0; stall_b = 1'b0;
      end else begin
        if (stall_b) check("hold_b", {mv_b, ml_b, md_b}, {1'b1, held_b});
        if (mv_b && m_ready) begin
          rec_b.push_back({ml_b, md_b});
          if (exp_b.size() == 0) check("extra_blk_b", exp_b.size(), 1);
          else check("blk_b", {ml_b, md_b}, exp_b.pop_front());
        end
        stall_b = mv_b && !m_ready;
        held_b = {ml_b, md_b};
        if (s_valid && ready_b) begin
          model_byte(fb_b, s_data, cur_b, n_b, pos_b, nb, b0, b1);
          if (nb > 0) exp_b.push_back(b0);
          if (nb > 1) exp_b.push_back(b1);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input bit sel, output int w);
    s_valid = 1'b1; s_data = d; w = 0;
    forever begin
      @(negedge clk);
      if (sel ? ready_b : ready_a) break;
      w++;
      if (w > 200) begin check("send_timeout", w, 0); break; end
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int w, tot;
    rst = 1'b1; clr = 1'b0; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b1; frame_len = 16'd0;
    #12;
    check("rst_mv_a", mv_a, 0);
    check("rst_md_a", md_a, 0);
    check("rst_ml_a", ml_a, 0);
    check("rst_rdy_a", ready_a, 1);
    check("rst_mv_b", mv_b, 0);
    check("rst_rdy_b", ready_b, 1);
    @(posedge clk); #1 rst = 1'b0;
    tick(1);

    // Full default frame
    rec_a.delete(); rec_b.delete();
    for (int i = 0; i < 181; i++) send(8'(i), 1'b0, w);
    tick(4);
    check("f181_cnt", rec_a.size(), 23);
    check("f181_b0", rec_get(0, 0), {1'b0, 64'h0001020304050607});
    check("f181_b21", rec_get(0, 21), {1'b0, 64'hA8A9AAABACADAEAF});
    check("f181_b22", rec_get(0, 22), {1'b1, 64'hB0B1B2B3B4800000});

    // 16-byte frame on instance b: full end block then a pad block
    do_clear();
    rec_a.delete(); rec_b.delete();
    for (int i = 0; i < 16; i++) send(8'h10 + 8'(i), 1'b1, w);
    check("pad_rdy_b", ready_b, 0);
    tick(1);
    check("pad_exit_rdy_b", ready_b, 1);
    tick(3);
    check("f16_cnt", rec_b.size(), 3);
    check("f16_b0", rec_get(1, 0), {1'b0, 64'h1011121314151617});
    check("f16_b1", rec_get(1, 1), {1'b0, 64'h18191A1B1C1D1E1F});
    check("f16_b2", rec_get(1, 2), {1'b1, 64'h8000000000000000});

    // Backpressure, then simultaneous retire/load
    do_clear();
    rec_a.delete(); rec_b.delete();
    for (int i = 0; i < 8; i++) send(8'(i), 1'b0, w);
    m_ready = 1'b0;
    tot = 0;
    for (int i = 8; i < 15; i++) begin send(8'(i), 1'b0, w); tot += w; end
    check("bp_accept7_waits", tot, 0);
    s_valid = 1'b1; s_data = 8'h0F;
    @(negedge clk);
    check("bp_stall_rdy", ready_a, 0);
    check("bp_hold_mv", mv_a, 1);
    check("bp_hold_data", md_a, 64'h0001020304050607);
    @(posedge clk); #1 m_ready = 1'b1;
    @(negedge clk);
    check("sim_rdy", ready_a, 1);
    @(posedge clk); #1 s_valid = 1'b0;
    @(negedge clk);
    check("sim_valid", mv_a, 1);
    check("sim_data", md_a, 64'h08090A0B0C0D0E0F);
    tick(2);
    check("bp_cnt", rec_a.size(), 2);
    check("bp_b0", rec_get(0, 0), {1'b0, 64'h0001020304050607});
    check("bp_b1", rec_get(0, 1), {1'b0, 64'h08090A0B0C0D0E0F});

    // Clear with a pending block, then a full frame from lane 0
    do_clear();
    m_ready = 1'b0;
    for (int i = 0; i < 11; i++) send(8'hA0 + 8'(i), 1'b0, w);
    check("clr_pending_mv", mv_a, 1);
    do_clear();
    check("clr_mv", mv_a, 0);
    check("clr_md", md_a, 0);
    check("clr_rdy", ready_a, 1);
    m_ready = 1'b1;
    rec_a.delete(); rec_b.delete();
    for (int i = 0; i < 8; i++) send(8'hC0 + 8'(i), 1'b0, w);
    tick(2);
    check("clr_b0", rec_get(0, 0), {1'b0, 64'hC0C1C2C3C4C5C6C7});
    for (int i = 8; i < 181; i++) send(8'(i), 1'b0, w);
    tick(3);
    check("clr_frame_cnt", rec_a.size(), 23);
    check("clr_frame_last", rec_get(0, 22), {1'b1, 64'hB0B1B2B3B4800000});

    // Asynchronous reset mid-cycle with a pending block
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(8'h30 + 8'(i), 1'b0, w);
    #2 rst = 1'b1;
    #1;
    check("arst_mv_a", mv_a, 0);
    check("arst_md_a", md_a, 0);
    check("arst_ml_a", ml_a, 0);
    check("arst_rdy_a", ready_a, 1);
    check("arst_mv_b", mv_b, 0);
    @(posedge clk); #1 rst = 1'b0;
    m_ready = 1'b1;
    rec_a.delete(); rec_b.delete();
    for (int i = 0; i < 8; i++) send(8'hC0 + 8'(i), 1'b0, w);
    tick(2);
    check("arst_b0", rec_get(0, 0), {1'b0, 64'hC0C1C2C3C4C5C6C7});

`ifdef BLOCK_PACKER_RTLEN_EN
    fb_a = 10; fb_b = 10; frame_len = 16'd10;
    do_clear();
    rec_a.delete(); rec_b.delete();
    for (int i = 0; i < 10; i++) send(8'(i), 1'b0, w);
    tick(3);
    check("rtlen_b0", rec_get(0, 0), {1'b0, 64'h0001020304050607});
    check("rtlen_b1", rec_get(0, 1), {1'b1, 64'h0809800000000000});
    frame_len = 16'd0; fb_a = 181; fb_b = 16;
`endif

    // Randomised traffic with occasional aborts
    do_clear();
    for (int c = 0; c < 4000; c++) begin
      s_valid = ($urandom_range(0, 9) < 7);
      s_data  = 8'($urandom);
      m_ready = ($urandom_range(0, 9) < 6);
      clr     = ($urandom_range(0, 599) == 0);
      tick(1);
    end
    clr = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    tick(30);
    check("drain_a", exp_a.size(), 0);
    check("drain_b", exp_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
